operand_shift_register: RTL and testbench
=========================================

Name: operand_shift_register

Overview:
- Parametrised, clocked operand register for the sequential multiplier/divider datapath; supersedes the strobe-written fixed 32-bit operand registers.
- Accepts an operand through a valid/ready load handshake, then performs a counted sequence of single-bit left/right shifts or rotates under datapath control.
- Signals completion after a programmable number of shift steps.
- Exposes the full value plus the MSB/LSB taps that the ALU control path consumes.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- STEPS, 32, number of shift steps per operation (1..WIDTH); the operation completes after exactly STEPS shifts.
- CNT_W, 6, width of step counter; must satisfy 2**CNT_W > STEPS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  load request.
- load_ready  output  1  register can accept a load this cycle.
- load_data  input  WIDTH  operand to load.
- start  input  1  begin shift sequence (sampled in LOADED only).
- shift_en  input  1  perform one shift step this cycle (SHIFTING only).
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 rotate left.
- serial_in  input  1  bit inserted at LSB (shl) or MSB (shr).
- clear  input  1  synchronous clear to IDLE, any state.
- operand_out  output  WIDTH  current register contents.
- msb_out  output  1  operand_out[WIDTH-1].
- lsb_out  output  1  operand_out[0].
- busy  output  1  high in SHIFTING.
- done  output  1  one-cycle pulse on the cycle after the final step.
- step_count  output  CNT_W  shift steps performed in the current operation.

Behaviour:
- Reset (async, any time, including mid-operation):
  - Forces state IDLE, register 0, step_count 0, done 0, busy 0, load_ready 1.
  - Takes effect immediately on rst assertion, independent of clk.
- States: IDLE, LOADED, SHIFTING, DONE.
- IDLE:
  - load_ready=1.
  - load_valid -> register<=load_data, step_count<=0, state LOADED next edge.
  - start ignored.
- LOADED:
  - load_ready=1.
  - load_valid reloads the register (stays LOADED).
  - start with no load_valid -> SHIFTING, step_count<=0.
  - load_valid and start together: load wins; start is dropped and the state stays LOADED.
- SHIFTING:
  - load_ready=0; load_valid is ignored and not queued.
  - Each cycle with shift_en=1 and mode!=00:
    - 01: reg<={reg[WIDTH-2:0],serial_in}.
    - 10: reg<={serial_in,reg[WIDTH-1:1]}.
    - 11: reg<={reg[WIDTH-2:0],reg[WIDTH-1]}.
    - step_count increments by 1.
  - shift_en=0 or mode=00: register and step_count hold; not counted.
  - The edge on which step_count reaches STEPS moves the state to DONE.
  - mode may change between steps; each step uses the mode present on that cycle.
- DONE:
  - done=1 for exactly the first cycle in DONE; busy=0; load_ready=1.
  - Register holds the result; step_count holds STEPS.
  - load_valid -> load, go to LOADED. start -> re-run the sequence on the current value (SHIFTING, step_count<=0). load_valid wins if both are asserted.
  - Otherwise remains in DONE with done=0 after the first cycle.
- clear: synchronous; highest priority after rst. Next edge: IDLE, register 0, step_count 0; done/busy drop.
- Latency: the loaded value is visible on operand_out the cycle after the accepting edge. Each step's result is visible the cycle after its edge.
- Outputs are registered state or direct decodes of it. No combinational path from any input to any output.
- msb_out/lsb_out always track operand_out.

Test Plan:
- Reset/load: assert rst mid-clock, release. Then load_valid with load_data=0xDEADBEEF -> operand_out 0 during reset; load_ready=1; next cycle operand_out=0xDEADBEEF, state LOADED.
- Shift left: load 0x00000001, start, mode=01, serial_in=0, shift_en held high -> after 31 steps operand_out=0x80000000, msb_out=1; after step 32 operand_out=0; done pulses once; step_count=32; busy low.
- Shift right with stalls: load 0x80000000, mode=10, serial_in=1, shift_en toggling 1/0 -> step_count increments only on enabled cycles; done after 32 enabled steps with operand_out=0xFFFFFFFF.
- Rotate and mode hold: load 0x80000001, mode=11 for 4 steps, mode=00 for 3 cycles, mode=11 for the remaining 28 -> operand_out returns to 0x80000001 at done; step_count frozen during the mode=00 cycles.
- Contention: load_valid during SHIFTING -> load_ready=0, register unchanged. load_valid+start together in LOADED -> load taken, state LOADED, busy stays 0.
- Abort: rst pulse at step 10 of SHIFTING -> operand_out=0, step_count=0, busy=0, no done pulse. Repeat with clear -> same result on the next edge.

Source files
------------

// File: rtl/operand_shift_register.sv
// Operand register for the sequential multiply/divide datapath. It takes an operand
// through a valid/ready load, then runs a counted sequence of single-bit shift or rotate steps.
module operand_shift_register #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             shift_en,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic             clear,
  output logic [WIDTH-1:0] operand_out,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_LOADED   = 2'b01,
    S_SHIFTING = 2'b10,
    S_DONE     = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_SHL  = 2'b01,
    M_SHR  = 2'b10,
    M_ROL  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS);

  state_e           state_q;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] shift_d;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] step_d;
  logic             done_q;
  logic             step_fire;

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    shift_d = operand_q;
    case (mode_e'(mode))
      M_SHL:   shift_d = {operand_q[WIDTH-2:0], serial_in};
      M_SHR:   shift_d = {serial_in, operand_q[WIDTH-1:1]};
      M_ROL:   shift_d = {operand_q[WIDTH-2:0], operand_q[WIDTH-1]};
      default: shift_d = operand_q;
    endcase
  end

  assign step_fire = shift_en && (mode != 2'b00);
  assign step_d    = step_q + CNT_W'(1);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      step_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q   <= S_IDLE;
        operand_q <= '0;
        step_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (load_valid) begin
              operand_q <= load_data;
              step_q    <= '0;
              state_q   <= S_LOADED;
            end
          end
          S_LOADED: begin
            // A load in the same cycle as start wins and drops the start.
            if (load_valid) begin
              operand_q <= load_data;
              step_q    <= '0;
            end else if (start) begin
              step_q  <= '0;
              state_q <= S_SHIFTING;
            end
          end
          S_SHIFTING: begin
            if (step_fire) begin
              operand_q <= shift_d;
              step_q    <= step_d;
              if (step_d == LAST_STEP) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (load_valid) begin
              operand_q <= load_data;
              step_q    <= '0;
              state_q   <= S_LOADED;
            end else if (start) begin
              step_q  <= '0;
              state_q <= S_SHIFTING;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign operand_out = operand_q;
  assign msb_out     = operand_q[WIDTH-1];
  assign lsb_out     = operand_q[0];
  assign step_count  = step_q;
  assign busy        = (state_q == S_SHIFTING);
  assign load_ready  = (state_q != S_SHIFTING);
  assign done        = done_q;

endmodule

// File: tb/tb_operand_shift_register.sv
// Directed-vector bench for operand_shift_register with hand-computed expectations.
module tb_operand_shift_register;

  logic        clk = 1'b0;
  logic        rst, load_valid, start, shift_en, serial_in, clear;
  logic [1:0]  mode;
  logic [31:0] load_data;
  logic        load_ready, msb_out, lsb_out, busy, done;
  logic [31:0] operand_out;
  logic [5:0]  step_count;

  int vectors = 0;
  int miscompares = 0;

  operand_shift_register #(.WIDTH(32), .STEPS(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .start(start), .shift_en(shift_en), .mode(mode),
    .serial_in(serial_in), .clear(clear), .operand_out(operand_out),
    .msb_out(msb_out), .lsb_out(lsb_out), .busy(busy), .done(done),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] v);
    load_valid = 1'b1;
    load_data  = v;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_val;
    int          exp_step;
    int          done_seen;

    rst = 1'b0; load_valid = 1'b0; start = 1'b0; shift_en = 1'b0;
    serial_in = 1'b0; clear = 1'b0; mode = 2'b00; load_data = '0;

    // Reset asserted mid-cycle, with a load presented while still in reset.
    #3 rst = 1'b1;
    #1;
    check("rst_operand", operand_out, 32'h0);
    check("rst_step", 32'(step_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = 32'hDEADBEEF;
    tick();
    check("rst_hold_load", operand_out, 32'h0);
    rst = 1'b0;
    tick();
    load_valid = 1'b0;
    check("load_value", operand_out, 32'hDEADBEEF);
    check("load_ready_loaded", 32'(load_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd0);

    // Shift left of a single one through the whole word.
    do_load(32'h00000001);
    check("shl_lsb", 32'(lsb_out), 32'd1);
    do_start();
    check("shl_busy", 32'(busy), 32'd1);
    check("shl_step0", 32'(step_count), 32'd0);
    mode = 2'b01; serial_in = 1'b0; shift_en = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    check("shl_31_val", operand_out, 32'h80000000);
    check("shl_31_msb", 32'(msb_out), 32'd1);
    check("shl_31_step", 32'(step_count), 32'd31);
    check("shl_31_busy", 32'(busy), 32'd1);
    tick();
    check("shl_32_val", operand_out, 32'h0);
    check("shl_32_done", 32'(done), 32'd1);
    check("shl_32_step", 32'(step_count), 32'd32);
    check("shl_32_busy", 32'(busy), 32'd0);
    check("shl_32_ready", 32'(load_ready), 32'd1);
    tick();
    check("shl_done_pulse", 32'(done), 32'd0);
    check("shl_hold_step", 32'(step_count), 32'd32);
    check("shl_hold_val", operand_out, 32'h0);
    shift_en = 1'b0;

    // Shift right with serial ones and every other cycle stalled.
    do_load(32'h80000000);
    do_start();
    mode = 2'b10; serial_in = 1'b1;
    exp_val = 32'h80000000;
    exp_step = 0;
    done_seen = 0;
    for (int i = 0; i < 63; i++) begin
      shift_en = (i % 2 == 0);
      if (shift_en) begin
        exp_val  = {1'b1, exp_val[31:1]};
        exp_step = exp_step + 1;
      end
      tick();
      check("shr_val", operand_out, exp_val);
      check("shr_step", 32'(step_count), 32'(exp_step));
      if (done) done_seen++;
    end
    check("shr_final", operand_out, 32'hFFFFFFFF);
    check("shr_done", 32'(done), 32'd1);
    check("shr_done_count", 32'(done_seen), 32'd1);
    shift_en = 1'b0;

    // Rotate four, hold three, rotate the remaining 28.
    do_load(32'h80000001);
    do_start();
    mode = 2'b11; shift_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("rol_4_val", operand_out, 32'h00000018);
    check("rol_4_step", 32'(step_count), 32'd4);
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rol_hold_step", 32'(step_count), 32'd4);
      check("rol_hold_val", operand_out, 32'h00000018);
    end
    mode = 2'b11;
    for (int i = 0; i < 27; i++) tick();
    check("rol_31_busy", 32'(busy), 32'd1);
    tick();
    check("rol_final", operand_out, 32'h80000001);
    check("rol_done", 32'(done), 32'd1);
    check("rol_step", 32'(step_count), 32'd32);
    shift_en = 1'b0;

    // Start from DONE reruns on the current value.
    do_start();
    check("rerun_busy", 32'(busy), 32'd1);
    check("rerun_step", 32'(step_count), 32'd0);
    check("rerun_val", operand_out, 32'h80000001);

    // Load during SHIFTING is refused.
    check("shift_ready", 32'(load_ready), 32'd0);
    do_load(32'hFFFF0000);
    check("shift_load_ignored", operand_out, 32'h80000001);
    check("shift_load_busy", 32'(busy), 32'd1);

    // Clear, then start in IDLE is ignored.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_val", operand_out, 32'h0);
    check("clr_busy", 32'(busy), 32'd0);
    do_start();
    check("idle_start_ignored", 32'(busy), 32'd0);

    // Load and start together in LOADED: load wins.
    do_load(32'hA5A5A5A5);
    load_valid = 1'b1; start = 1'b1; load_data = 32'h0F0F0F0F;
    tick();
    load_valid = 1'b0; start = 1'b0;
    check("both_val", operand_out, 32'h0F0F0F0F);
    check("both_busy", 32'(busy), 32'd0);
    check("both_ready", 32'(load_ready), 32'd1);
    do_start();
    check("both_then_start", 32'(busy), 32'd1);

    // Async reset at step 10.
    mode = 2'b01; serial_in = 1'b0; shift_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("abort_step10", 32'(step_count), 32'd10);
    check("abort_val10", operand_out, 32'h3C3C3C00);
    #2 rst = 1'b1;
    #1;
    check("abort_rst_val", operand_out, 32'h0);
    check("abort_rst_step", 32'(step_count), 32'd0);
    check("abort_rst_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_rst_no_done", 32'(done_seen), 32'd0);

    // Same abort via synchronous clear.
    shift_en = 1'b0;
    do_load(32'h0F0F0F0F);
    do_start();
    shift_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("clr_abort_step10", 32'(step_count), 32'd10);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_abort_val", operand_out, 32'h0);
    check("clr_abort_step", 32'(step_count), 32'd0);
    check("clr_abort_busy", 32'(busy), 32'd0);
    check("clr_abort_done", 32'(done), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("clr_abort_no_done", 32'(done_seen), 32'd0);
    shift_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
